// File: rtl/elevator_ctrl.sv
// Collective (SCAN) elevator sequencer: latches debounced floor requests and
// drives travel/door timing, floor display, motion indicators and request lamps.
module elevator_ctrl #(
  parameter int N_FLOORS   = 4,
  parameter int FW         = $clog2(N_FLOORS),
  parameter int TRAVEL_CYC = 50_000_000,
  parameter int DOOR_CYC   = 100_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] req_car,
  input  logic [N_FLOORS-1:0] req_hall,
  output logic [FW-1:0]       floor,
  output logic                moving,
  output logic                up,
  output logic                down,
  output logic                door_open,
  output logic [N_FLOORS-1:0] car_lamp,
  output logic [N_FLOORS-1:0] hall_lamp
);

  localparam int TMAX = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
  localparam int TW   = $clog2(TMAX);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MOVE = 2'd1;
  localparam logic [1:0] S_DOOR = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [FW-1:0]       floor_q, floor_d;
  logic                dir_q, dir_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [N_FLOORS-1:0] car_q, car_d;
  logic [N_FLOORS-1:0] hall_q, hall_d;

  logic [N_FLOORS-1:0] pend, fl_oh, nf_oh, latch_mask;
  logic [FW-1:0]       nf;
  logic                above, below, ahead_nf, here, nf_here, req_here;
  logic                travel_done, door_done;

  // Floor decodes and the above/below/ahead summaries of the pending set.
  always_comb begin
    pend     = car_q | hall_q;
    nf       = dir_q ? (floor_q + FW'(1)) : (floor_q - FW'(1));
    above    = 1'b0;
    below    = 1'b0;
    ahead_nf = 1'b0;
    fl_oh    = '0;
    nf_oh    = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      fl_oh[i] = (FW'(i) == floor_q);
      nf_oh[i] = (FW'(i) == nf);
      if (pend[i] && (FW'(i) > floor_q)) above = 1'b1;
      if (pend[i] && (FW'(i) < floor_q)) below = 1'b1;
      if (pend[i] && (dir_q ? (FW'(i) > nf) : (FW'(i) < nf))) ahead_nf = 1'b1;
    end
    here        = |(pend & fl_oh);
    nf_here     = |(pend & nf_oh);
    req_here    = |((req_car | req_hall) & fl_oh);
    travel_done = (timer_q == TW'(TRAVEL_CYC - 1));
    door_done   = (timer_q == TW'(DOOR_CYC - 1));
  end

  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    dir_d   = dir_q;
    timer_d = timer_q + TW'(1);
    // While the door is open, a press for this floor only extends the door.
    latch_mask = (state_q == S_DOOR) ? ~fl_oh : '1;
    car_d      = car_q  | (req_car  & latch_mask);
    hall_d     = hall_q | (req_hall & latch_mask);
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (here) begin
          state_d = S_DOOR;
          car_d   = car_d  & ~fl_oh;
          hall_d  = hall_d & ~fl_oh;
        end else if (above && (dir_q || !below)) begin
          dir_d   = 1'b1;
          state_d = S_MOVE;
        end else if (below) begin
          dir_d   = 1'b0;
          state_d = S_MOVE;
        end
      end
      S_MOVE: begin
        if (travel_done) begin
          timer_d = '0;
          floor_d = nf;
          if (nf_here) begin
            state_d = S_DOOR;
            car_d   = car_d  & ~nf_oh;
            hall_d  = hall_d & ~nf_oh;
          end else if (!ahead_nf) begin
            state_d = S_IDLE;
          end
        end
      end
      S_DOOR: begin
        if (req_here) begin
          timer_d = '0;
        end else if (door_done) begin
          timer_d = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      floor_q <= '0;
      dir_q   <= 1'b1;
      timer_q <= '0;
      car_q   <= '0;
      hall_q  <= '0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      dir_q   <= dir_d;
      timer_q <= timer_d;
      car_q   <= car_d;
      hall_q  <= hall_d;
    end
  end

  assign floor     = floor_q;
  assign moving    = (state_q == S_MOVE);
  assign up        = moving && dir_q;
  assign down      = moving && !dir_q;
  assign door_open = (state_q == S_DOOR);
  assign car_lamp  = car_q;
  assign hall_lamp = hall_q;

endmodule

// File: doc/elevator_ctrl.md
Name: elevator_ctrl

Overview:
- Elevator scheduler/sequencer. Sits downstream of the keypad scan and debounce logic.
- Latches single-cycle debounced floor requests from car and hall buttons.
- Runs a collective (SCAN) policy: keeps travelling in the current direction while requests lie ahead, otherwise reverses.
- Sequences travel and door timing, and drives the floor display, direction/motion indicators and request lamps.

Parameters:
N_FLOORS, 4, number of floors (2..8); floors numbered 0..N_FLOORS-1.
FW, $clog2(N_FLOORS), floor index width.
TRAVEL_CYC, 50_000_000, clk cycles to travel one floor (>=2).
DOOR_CYC, 100_000_000, clk cycles door stays open (>=2).

Ports:
clk  in  1  system clock; all state on rising edge.
rst  in  1  asynchronous, active-low reset.
req_car  in  N_FLOORS  car-panel floor requests, one-cycle pulses from debouncers.
req_hall  in  N_FLOORS  hall-call requests, one-cycle pulses (direction not distinguished).
floor  out  FW  current floor.
moving  out  1  high while in MOVE.
up  out  1  moving && dir==up.
down  out  1  moving && dir==down.
door_open  out  1  high while in DOOR.
car_lamp  out  N_FLOORS  latched car requests.
hall_lamp  out  N_FLOORS  latched hall requests.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, floor=0, dir=up, timer=0, lamps=0.
  - All outputs are 0 (floor=0).
  - Reset mid-move or mid-door aborts immediately; no request survives.
- Latching: car_lamp |= req_car and hall_lamp |= req_hall each cycle. pending = car_lamp | hall_lamp.
  - Exception: the bit for the current floor is not set while in DOOR; instead it restarts the door timer.
- above = any pending bit > floor; below = any pending bit < floor; here = pending[floor].
- IDLE:
  - If here: go to DOOR, clear car_lamp[floor] and hall_lamp[floor], timer=0.
  - Else if above and (dir==up or !below): dir=up, go to MOVE, timer=0.
  - Else if below: dir=down, go to MOVE, timer=0.
  - Else stay in IDLE; dir holds.
- MOVE:
  - timer increments each cycle. When timer==TRAVEL_CYC-1, floor steps ±1 per dir and timer=0.
  - On that same edge the next state is chosen from pending at the new floor:
    - pending[new] → DOOR, clearing both lamps for the new floor.
    - Else requests remain beyond the new floor in dir → stay in MOVE.
    - Else → IDLE.
  - The direction never changes inside MOVE.
  - floor never leaves 0..N_FLOORS-1: at floor 0 "below" is empty, at N_FLOORS-1 "above" is empty.
- DOOR:
  - door_open=1. timer counts to DOOR_CYC-1, then goes to IDLE.
  - A request pulse for the current floor during DOOR resets timer to 0 and is not latched.
  - Requests for other floors latch normally.
- Latency:
  - A request pulse sampled at edge t is visible in the lamps after t.
  - The IDLE decision is taken at edge t+1, so moving/door_open is high from edge t+1.
  - A request for the current floor while IDLE opens the door 1 cycle after the lamp sets; the lamp is cleared on the same edge.
- Simultaneous events:
  - Pulses on req_car and req_hall for the same floor set both lamps; both clear together on service.
  - A request arriving on the cycle the lamp for that floor is being cleared at arrival is absorbed: the clear wins, no re-latch.
  - A request for the floor just departed (MOVE, timer=0) is latched and served after reversal.
- Outputs are registered or decoded from state only; there is no combinational path from req_* to any output.

Test Plan (TRAVEL_CYC=4, DOOR_CYC=3, N_FLOORS=4):
- Reset, then a req_car[2] pulse:
  - car_lamp=0100 on the next cycle, then up=1.
  - floor steps 0→1→2, 4 cycles each.
  - door_open=1 for 3 cycles with car_lamp=0000, then IDLE with all indicators 0.
- At floor 0 idle, req_car[0] pulse:
  - No motion; door_open for 3 cycles; lamp cleared when the door opens.
  - A second req_hall[0] pulse during DOOR restarts the door timer, so the door is open 3 cycles after that pulse; hall_lamp stays 0.
- From floor 0 moving up to 3, inject req_hall[1] while floor=0 mid-travel and req_car[0] at the same time:
  - Stops at 1 (door, hall_lamp[1] cleared), continues to 3 with up=1.
  - Then reverses to 0 with down=1.
- At floor 2 idle with dir=up, pending {0,3} latched together: goes up to 3 first (dir retained), then down to 0.
- Assert rst low while moving between floors 1 and 2 with lamps set: all outputs 0 and floor=0 asynchronously; after release the block stays IDLE.
- Same-cycle req_car[3] and req_hall[3] pulses: both lamps set, both clear on arrival at 3, single door cycle.
